// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control sequencer and the decode/hazard logic.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OPC_HLT = 4'hF;

    function automatic logic is_hlt(input logic [3:0] opc);
        return opc == OPC_HLT;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: stage enables/flushes, halt drain and stall/flush statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             hz_flush,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic             id_halt,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state;
    logic [1:0] dcnt;
    logic       stall_inc;
    logic       flush_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            dcnt  <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (!dcache_miss && !hz_stall && !hz_flush && id_halt) begin
                        state <= ST_DRAIN;
                        dcnt  <= 2'd2;
                    end
                end
                ST_DRAIN: begin
                    if (!dcache_miss) begin
                        if (dcnt == 2'd0) state <= ST_HALTED;
                        else              dcnt  <= dcnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset forces every control low regardless of state, so the decode is gated by rst first.
    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        memwb_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_RUN: begin
                    if (dcache_miss) begin
                        stall_inc = 1'b1;
                    end else if (hz_stall) begin
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (hz_flush) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (id_halt || icache_miss) begin
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        stall_inc  = 1'b1;
                    end else begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!dcache_miss) begin
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                    end
                end
                ST_HALTED: halted = 1'b1;
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule
